// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative encryption core:
//   - SBOX table and sbox() lookup
//   - xtime / gmul2 / gmul3 GF(2^8) helpers for MixColumns
//   - RCON round constants and a range-safe rcon_at() lookup
//   - sub_word / rot_word key-schedule helpers
//   - aes_state_e control state enum
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Out-of-range indices (e.g. while the round counter is idle at 0)
  // return 0 instead of reading past the table.
  function automatic logic [7:0] rcon_at(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_iter_core_if.sv
// ---------------------------------------------------------------------------
// aes_iter_core_if
// Block-level handshake bundle for aes_iter_core.
//   in_valid/in_ready   : plaintext + key accept handshake
//   plaintext [127:0]   : FIPS-197 byte order, byte 0 in [127:120]
//   key [KEY_BITS-1:0]  : cipher key, word w0 in the MSBs
//   out_valid/out_ready : ciphertext handshake
//   cipher [127:0]      : ciphertext, same byte order as plaintext
// master = block producer/consumer side, slave = the core.
// ---------------------------------------------------------------------------
interface aes_iter_core_if #(
  parameter int KEY_BITS = 128
);
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        plaintext;
  logic [KEY_BITS-1:0] key;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        cipher;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, cipher
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, cipher
  );
endinterface

// File: rtl/aes_round.sv
// ---------------------------------------------------------------------------
// aes_round
// Combinational single AES encryption round.
//   state_in  [127:0] : current state, byte 0 in [127:120], column-major
//   round_key [127:0] : key added at the end of the round
//   last_round        : skip MixColumns (final round)
//   state_out [127:0] : SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey
// ---------------------------------------------------------------------------
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] state_out
);

  logic [7:0]   sub_bytes [16];
  logic [7:0]   shifted   [16];
  logic [127:0] shift_flat;
  logic [127:0] mix_flat;

  // Byte index gi = 4*column + row. Row r rotates left by r columns.
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    assign sub_bytes[gi] = sbox(state_in[127-8*gi -: 8]);
    assign shifted[gi]   = sub_bytes[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
    assign shift_flat[127-8*gi -: 8] = shifted[gi];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = shifted[4*gi];
    assign a1 = shifted[4*gi+1];
    assign a2 = shifted[4*gi+2];
    assign a3 = shifted[4*gi+3];
    assign mix_flat[127-32*gi -: 32] = {
      gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3,
      a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3,
      a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3),
      gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3)
    };
  end

  assign state_out = (last_round ? shift_flat : mix_flat) ^ round_key;

endmodule

// File: rtl/aes_iter_core.sv
// ---------------------------------------------------------------------------
// aes_iter_core
// Iterative AES-128/AES-256 encryption engine, one round per clock, with
// on-the-fly key expansion. One block in flight at a time.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   bus       : aes_iter_core_if.slave (in/out valid-ready, plaintext, key,
//               cipher)
//   busy      : high while rounds are being computed
// Parameter KEY_BITS: 128 or 256 (anything else fails elaboration).
// Optional macro AES_ITER_SCRUB_EN: zero state, key and cipher registers on
// the output handshake so no key material or ciphertext lingers.
// ---------------------------------------------------------------------------
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
)
(
  input  logic           clock,
  input  logic           reset,
  aes_iter_core_if.slave bus,
  output logic           busy
);

  localparam int         NR      = (KEY_BITS == 256) ? 14 : 10;
  localparam logic [3:0] NR_LAST = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_iter_core: KEY_BITS must be 128 or 256");
  end

  aes_state_e          fsm_reg;
  aes_state_e          fsm_next;
  logic [127:0]        state_reg;
  logic [KEY_BITS-1:0] key_reg;
  logic [127:0]        cipher_reg;
  logic [3:0]          rnd_reg;

  logic                accept;
  logic                last_round;
  logic [127:0]        round_key;
  logic [127:0]        round_out;
  logic [KEY_BITS-1:0] key_step;

  assign last_round = (rnd_reg == NR_LAST);

  // -------------------------------------------------------------------------
  // Key expansion. key_step is the key register value after this round;
  // round_key is the key added in round rnd_reg.
  // -------------------------------------------------------------------------
  if (KEY_BITS == 256) begin : g_ks256
    logic [31:0]         kw [8];
    logic [31:0]         nw [8];
    logic [7:0]          rc;
    logic [KEY_BITS-1:0] key_adv;

    for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
      assign kw[gi] = key_reg[KEY_BITS-1-32*gi -: 32];
      assign key_adv[KEY_BITS-1-32*gi -: 32] = nw[gi];
    end

    assign rc    = rcon_at((rnd_reg >> 1) - 4'd1);
    assign nw[0] = kw[0] ^ sub_word(rot_word(kw[7])) ^ {rc, 24'h000000};
    for (genvar gi = 1; gi < 4; gi++) begin : g_first_half
      assign nw[gi] = kw[gi] ^ nw[gi-1];
    end
    // Second half step uses SubWord only (no rotate, no Rcon).
    assign nw[4] = kw[4] ^ sub_word(nw[3]);
    for (genvar gi = 5; gi < 8; gi++) begin : g_second_half
      assign nw[gi] = kw[gi] ^ nw[gi-1];
    end

    // Odd rounds consume the lower half of the current register; even
    // rounds advance by eight words and consume the new upper half.
    assign round_key = rnd_reg[0] ? key_reg[127:0] : key_adv[KEY_BITS-1 -: 128];
    assign key_step  = rnd_reg[0] ? key_reg : key_adv;
  end else begin : g_ks128
    logic [31:0]         kw [4];
    logic [31:0]         nw [4];
    logic [7:0]          rc;
    logic [KEY_BITS-1:0] key_adv;

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
      assign kw[gi] = key_reg[KEY_BITS-1-32*gi -: 32];
      assign key_adv[KEY_BITS-1-32*gi -: 32] = nw[gi];
    end

    assign rc    = rcon_at(rnd_reg - 4'd1);
    assign nw[0] = kw[0] ^ sub_word(rot_word(kw[3])) ^ {rc, 24'h000000};
    for (genvar gi = 1; gi < 4; gi++) begin : g_chain
      assign nw[gi] = kw[gi] ^ nw[gi-1];
    end

    assign round_key = key_adv;
    assign key_step  = key_adv;
  end

  aes_round u_round (
    .state_in   (state_reg),
    .round_key  (round_key),
    .last_round (last_round),
    .state_out  (round_out)
  );

  // -------------------------------------------------------------------------
  // Control FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_reg <= IDLE;
    end else begin
      fsm_reg <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      IDLE:    if (accept)        fsm_next = ROUND;
      ROUND:   if (last_round)    fsm_next = DONE;
      DONE:    if (bus.out_ready) fsm_next = IDLE;
      default:                    fsm_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (fsm_reg)
      // Held low while reset is asserted so nothing is accepted in the
      // reset cycle even though the register already reads IDLE.
      IDLE:    bus.in_ready  = ~reset;
      ROUND:   busy          = 1'b1;
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept     = bus.in_valid & bus.in_ready;
  assign bus.cipher = cipher_reg;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= '0;
      key_reg    <= '0;
      cipher_reg <= '0;
      rnd_reg    <= '0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= bus.plaintext ^ bus.key[KEY_BITS-1 -: 128];
            key_reg   <= bus.key;
            rnd_reg   <= 4'd1;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          key_reg   <= key_step;
          if (last_round) begin
            cipher_reg <= round_out;
            rnd_reg    <= 4'd0;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
          end
        end
        DONE: begin
`ifdef AES_ITER_SCRUB_EN
          if (bus.out_ready) begin
            state_reg  <= '0;
            key_reg    <= '0;
            cipher_reg <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// ---------------------------------------------------------------------------
// tb_aes_iter_core
// Self-checking bench for aes_iter_core: one AES-128 and one AES-256
// instance sharing clock and reset. Directed FIPS-197 vectors, latency,
// backpressure, mid-block reset and randomized blocks checked against a
// behavioural AES model (S-box derived from the GF(2^8) inverse).
// Honours AES_ITER_SCRUB_EN for post-handshake cipher expectations.
// ---------------------------------------------------------------------------
module tb_aes_iter_core;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy128;
  logic busy256;

  always #5 clock = ~clock;

  aes_iter_core_if #(.KEY_BITS(128)) bus128 ();
  aes_iter_core_if #(.KEY_BITS(256)) bus256 ();

  aes_iter_core #(.KEY_BITS(128)) u_dut128 (
    .clock (clock),
    .reset (reset),
    .bus   (bus128),
    .busy  (busy128)
  );

  aes_iter_core #(.KEY_BITS(256)) u_dut256 (
    .clock (clock),
    .reset (reset),
    .bus   (bus256),
    .busy  (busy256)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbox_tab [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] m_subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // k holds the key MSB-aligned (AES-128 keys in k[255:128]).
  function automatic logic [127:0] model_aes(input bit wide, input logic [255:0] k,
                                             input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [127:0] res;
    int nk = wide ? 8 : 4;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = m_subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = m_subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) t[row] = s[4*c+row];
          s[4*c]   = gf_mul(t[0], 8'h02) ^ gf_mul(t[1], 8'h03) ^ t[2] ^ t[3];
          s[4*c+1] = t[0] ^ gf_mul(t[1], 8'h02) ^ gf_mul(t[2], 8'h03) ^ t[3];
          s[4*c+2] = t[0] ^ t[1] ^ gf_mul(t[2], 8'h02) ^ gf_mul(t[3], 8'h03);
          s[4*c+3] = gf_mul(t[0], 8'h03) ^ t[1] ^ t[2] ^ gf_mul(t[3], 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input bit wide, input logic v, input logic [127:0] pt,
                        input logic [255:0] k);
    if (wide) begin
      bus256.in_valid = v; bus256.plaintext = pt; bus256.key = k;
    end else begin
      bus128.in_valid = v; bus128.plaintext = pt; bus128.key = k[255:128];
    end
  endtask

  task automatic set_out_ready(input bit wide, input logic v);
    if (wide) bus256.out_ready = v;
    else      bus128.out_ready = v;
  endtask

  function automatic logic get_in_ready(input bit wide);
    return wide ? bus256.in_ready : bus128.in_ready;
  endfunction

  function automatic logic get_out_valid(input bit wide);
    return wide ? bus256.out_valid : bus128.out_valid;
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? busy256 : busy128;
  endfunction

  function automatic logic [127:0] get_cipher(input bit wide);
    return wide ? bus256.cipher : bus128.cipher;
  endfunction

  // Called at #1 after the accept edge: counts edges until out_valid.
  task automatic wait_result(input bit wide, input logic [127:0] exp, input string tag);
    int n = 0;
    check({tag, "_busy"}, 128'(get_busy(wide)), 128'd1);
    check({tag, "_in_ready_busy"}, 128'(get_in_ready(wide)), 128'd0);
    while (!get_out_valid(wide) && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_latency"}, 128'(n), wide ? 128'd14 : 128'd10);
    check({tag, "_cipher"}, get_cipher(wide), exp);
    $display("blk %s wide=%0d cycles=%0d cipher=%h", tag, wide, n, get_cipher(wide));
  endtask

  task automatic start_block(input bit wide, input logic [127:0] pt, input logic [255:0] k,
                             input string tag);
    int n = 0;
    while (!get_in_ready(wide) && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_in_ready"}, 128'(get_in_ready(wide)), 128'd1);
    set_in(wide, 1'b1, pt, k);
    @(posedge clock); #1;
    // Scramble inputs: the block in flight must not see these.
    set_in(wide, 1'b0, rand128(), {rand128(), rand128()});
  endtask

  task automatic finish_block(input bit wide, input logic [127:0] exp, input string tag);
    logic [127:0] idle_exp;
`ifdef AES_ITER_SCRUB_EN
    idle_exp = 128'd0;
`else
    idle_exp = exp;
`endif
    set_out_ready(wide, 1'b1);
    @(posedge clock); #1;
    set_out_ready(wide, 1'b0);
    check({tag, "_out_valid_clr"}, 128'(get_out_valid(wide)), 128'd0);
    check({tag, "_in_ready_back"}, 128'(get_in_ready(wide)), 128'd1);
    check({tag, "_cipher_after"}, get_cipher(wide), idle_exp);
    repeat (3) @(posedge clock);
    #1;
    check({tag, "_cipher_idle"}, get_cipher(wide), idle_exp);
  endtask

  task automatic run_block(input bit wide, input logic [127:0] pt, input logic [255:0] k,
                           input logic [127:0] exp, input string tag);
    start_block(wide, pt, k, tag);
    wait_result(wide, exp, tag);
    finish_block(wide, exp, tag);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] KEY_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    logic [127:0] pt1, pt2, exp1, exp2, ptr;
    logic [255:0] k1, k2, kr;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));

    set_in(1'b0, 1'b0, '0, '0);
    set_in(1'b1, 1'b0, '0, '0);
    set_out_ready(1'b0, 1'b0);
    set_out_ready(1'b1, 1'b0);

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 128'(bus128.in_ready), 128'd0);
    check("rst_out_valid", 128'(bus128.out_valid), 128'd0);
    check("rst_cipher", bus128.cipher, 128'd0);
    check("rst_busy", 128'(busy128), 128'd0);
    check("rst_busy256", 128'(busy256), 128'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(bus128.in_ready), 128'd1);

    // out_ready in IDLE has no effect
    set_out_ready(1'b0, 1'b1);
    @(posedge clock); #1;
    set_out_ready(1'b0, 1'b0);
    check("idle_out_ready_valid", 128'(bus128.out_valid), 128'd0);
    check("idle_out_ready_in_ready", 128'(bus128.in_ready), 128'd1);

    // Directed vectors
    run_block(1'b0, PT_A, KEY_A, CT_A, "vec128_a");
    run_block(1'b0, PT_B, KEY_B, CT_B, "vec128_b");
    run_block(1'b1, PT_A, KEY_C, CT_C, "vec256");

    // Backpressure: hold DONE 20 cycles with a competing in_valid
    pt1 = rand128(); k1 = {rand128(), 128'h0}; exp1 = model_aes(1'b0, k1, pt1);
    pt2 = rand128(); k2 = {rand128(), 128'h0}; exp2 = model_aes(1'b0, k2, pt2);
    start_block(1'b0, pt1, k1, "bp1");
    wait_result(1'b0, exp1, "bp1");
    set_in(1'b0, 1'b1, pt2, k2);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      check("bp_hold_cipher", bus128.cipher, exp1);
      check("bp_hold_in_ready", 128'(bus128.in_ready), 128'd0);
      check("bp_hold_out_valid", 128'(bus128.out_valid), 128'd1);
    end
    set_out_ready(1'b0, 1'b1);
    @(posedge clock); #1;
    set_out_ready(1'b0, 1'b0);
    check("bp_release_valid", 128'(bus128.out_valid), 128'd0);
    check("bp_release_in_ready", 128'(bus128.in_ready), 128'd1);
    @(posedge clock); #1;
    set_in(1'b0, 1'b0, rand128(), {rand128(), rand128()});
    wait_result(1'b0, exp2, "bp2");
    finish_block(1'b0, exp2, "bp2");

    // Reset in round 5
    start_block(1'b0, PT_B, KEY_B, "rst_mid");
    repeat (4) @(posedge clock);
    #1;
    check("rst_mid_busy_before", 128'(busy128), 128'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_mid_in_ready_during", 128'(bus128.in_ready), 128'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 128'(busy128), 128'd0);
    check("rst_mid_out_valid", 128'(bus128.out_valid), 128'd0);
    check("rst_mid_cipher", bus128.cipher, 128'd0);
    check("rst_mid_in_ready", 128'(bus128.in_ready), 128'd1);
    repeat (15) @(posedge clock);
    #1;
    check("rst_mid_no_output", 128'(bus128.out_valid), 128'd0);
    run_block(1'b0, PT_A, KEY_A, CT_A, "after_rst");

    // Randomized blocks
    for (int i = 0; i < 6; i++) begin
      ptr = rand128(); kr = {rand128(), 128'h0};
      run_block(1'b0, ptr, kr, model_aes(1'b0, kr, ptr), "rand128");
    end
    for (int i = 0; i < 4; i++) begin
      ptr = rand128(); kr = {rand128(), rand128()};
      run_block(1'b1, ptr, kr, model_aes(1'b1, kr, ptr), "rand256");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
